// File: rtl/light_dir_norm_seq.sv
// Max-norm normaliser for the light direction vector.
// A signed Q8.8 (x,y,z) is accepted, the largest component magnitude m is
// found, and each component magnitude is divided by m on a single shared
// restoring divider (X, then Y, then Z). The result is a signed
// Q1.FRAC_BITS vector whose largest component is exactly +/-1.0.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid && ready are both high. The producer holds valid and data
// stable until that edge; ready never depends combinationally on valid.
// in_ready is high only while idle; out_valid stays high, with norm_* and
// zero_vec frozen, until the consumer's out_ready completes the transfer.
module light_dir_norm_seq #(
  parameter int W         = 16,
  parameter int FRAC_BITS = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dir_x,
  input  logic [W-1:0] dir_y,
  input  logic [W-1:0] dir_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] norm_x,
  output logic [W-1:0] norm_y,
  output logic [W-1:0] norm_z,
  output logic         zero_vec,
  output logic         busy
);

  // Magnitudes fit in W-1 bits once -2^(W-1) is saturated.
  localparam int MW = W - 1;
  // One quotient bit per iteration; the quotient can reach 2^FRAC_BITS.
  localparam int QW = FRAC_BITS + 1;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] ITER_LAST = CW'(FRAC_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAX   = 3'd1,
    S_DIV_X = 3'd2,
    S_DIV_Y = 3'd3,
    S_DIV_Z = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t state;

  // Captured operand: sign bit and saturated magnitude per component.
  logic          sign_x, sign_y, sign_z;
  logic [MW-1:0] mag_x, mag_y, mag_z;

  // Divisor (max magnitude), held for all three divides.
  logic [MW-1:0] m_reg;

  // Divider working registers. The partial remainder stays below 2*m, so
  // W bits are always enough. Only FRAC_BITS quotient bits need storing:
  // the last bit is appended combinationally on the final iteration.
  logic [W-1:0]         rem;
  logic [FRAC_BITS-1:0] quo;
  logic [CW-1:0]        cnt;

  // Finished X and Y results, published together with Z on entry to OUT.
  logic [W-1:0] res_x, res_y;

  // Saturating absolute value: -2^(W-1) has no positive twin, so clamp it.
  function automatic logic [MW-1:0] sat_mag(input logic [W-1:0] c);
    logic [MW-1:0] r;
    if (!c[W-1]) begin
      r = c[MW-1:0];
    end else if (c[MW-1:0] == '0) begin
      r = '1;
    end else begin
      r = ~c[MW-1:0] + 1'b1;
    end
    return r;
  endfunction

  // Max of the three captured magnitudes.
  logic [MW-1:0] max_xy;
  logic [MW-1:0] max_all;
  always_comb begin
    max_xy  = (mag_x >= mag_y) ? mag_x : mag_y;
    max_all = (max_xy >= mag_z) ? max_xy : mag_z;
  end

  // One restoring-division step: compare, conditionally subtract, shift.
  logic [W-1:0]  m_ext;
  logic          rem_ge;
  logic [W-1:0]  rem_sub;
  logic [W-1:0]  rem_next;
  logic [QW-1:0] quo_next;
  always_comb begin
    m_ext    = {1'b0, m_reg};
    rem_ge   = (rem >= m_ext);
    rem_sub  = rem_ge ? (rem - m_ext) : rem;
    rem_next = rem_sub << 1;
    quo_next = {quo, rem_ge};
  end

  // Apply the sign of the component currently being divided to the final
  // quotient; the divide itself is purely on magnitudes.
  logic         cur_sign;
  logic [W-1:0] quo_ext;
  logic [W-1:0] signed_q;
  logic         last_iter;
  always_comb begin
    cur_sign = sign_z;
    case (state)
      S_DIV_X: cur_sign = sign_x;
      S_DIV_Y: cur_sign = sign_y;
      default: cur_sign = sign_z;
    endcase
    quo_ext   = {{(W-QW){1'b0}}, quo_next};
    signed_q  = cur_sign ? (~quo_ext + 1'b1) : quo_ext;
    last_iter = (cnt == '0);
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Sequencer: capture, max, three divides, then hold the result for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sign_x    <= 1'b0;
      sign_y    <= 1'b0;
      sign_z    <= 1'b0;
      mag_x     <= '0;
      mag_y     <= '0;
      mag_z     <= '0;
      m_reg     <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      res_x     <= '0;
      res_y     <= '0;
      norm_x    <= '0;
      norm_y    <= '0;
      norm_z    <= '0;
      zero_vec  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_x   <= dir_x[W-1];
            sign_y   <= dir_y[W-1];
            sign_z   <= dir_z[W-1];
            mag_x    <= sat_mag(dir_x);
            mag_y    <= sat_mag(dir_y);
            mag_z    <= sat_mag(dir_z);
            zero_vec <= 1'b0;
            state    <= S_MAX;
          end
        end

        S_MAX: begin
          m_reg <= max_all;
          if (max_all == '0) begin
            // Nothing to divide by: report a zero vector directly.
            zero_vec <= 1'b1;
            norm_x   <= '0;
            norm_y   <= '0;
            norm_z   <= '0;
            state    <= S_OUT;
          end else begin
            rem   <= {1'b0, mag_x};
            quo   <= '0;
            cnt   <= ITER_LAST;
            state <= S_DIV_X;
          end
        end

        S_DIV_X: begin
          if (last_iter) begin
            res_x <= signed_q;
            rem   <= {1'b0, mag_y};
            quo   <= '0;
            cnt   <= ITER_LAST;
            state <= S_DIV_Y;
          end else begin
            rem <= rem_next;
            quo <= quo_next[FRAC_BITS-1:0];
            cnt <= cnt - 1'b1;
          end
        end

        S_DIV_Y: begin
          if (last_iter) begin
            res_y <= signed_q;
            rem   <= {1'b0, mag_z};
            quo   <= '0;
            cnt   <= ITER_LAST;
            state <= S_DIV_Z;
          end else begin
            rem <= rem_next;
            quo <= quo_next[FRAC_BITS-1:0];
            cnt <= cnt - 1'b1;
          end
        end

        S_DIV_Z: begin
          if (last_iter) begin
            // Publish all three components at once so the outputs only
            // move on entry to OUT.
            norm_x <= res_x;
            norm_y <= res_y;
            norm_z <= signed_q;
            state  <= S_OUT;
          end else begin
            rem <= rem_next;
            quo <= quo_next[FRAC_BITS-1:0];
            cnt <= cnt - 1'b1;
          end
        end

        S_OUT: begin
          // First OUT cycle raises out_valid; then wait for the consumer.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_dir_norm_seq.sv
// Bench for light_dir_norm_seq: directed cases plus random vectors, checked
// by a scoreboard fed from an arithmetic reference model.
module tb_light_dir_norm_seq;

  localparam int W  = 16;
  localparam int EW = 3 * W + 1;  // {zero_vec, norm_x, norm_y, norm_z}

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dir_x, dir_y, dir_z;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] norm_x, norm_y, norm_z;
  logic         zero_vec;
  logic         busy;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  light_dir_norm_seq #(.W(16), .FRAC_BITS(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .dir_z     (dir_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .norm_x    (norm_x),
    .norm_y    (norm_y),
    .norm_z    (norm_z),
    .zero_vec  (zero_vec),
    .busy      (busy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: normalise by the max magnitude with plain integer math.
  function automatic logic [EW-1:0] model(input int x, input int y, input int z);
    longint mx, my, mz, m, qx, qy, qz;
    logic [W-1:0] nx, ny, nz;
    mx = (x < 0) ? -x : x;  if (mx > 32767) mx = 32767;
    my = (y < 0) ? -y : y;  if (my > 32767) my = 32767;
    mz = (z < 0) ? -z : z;  if (mz > 32767) mz = 32767;
    m = mx;
    if (my > m) m = my;
    if (mz > m) m = mz;
    if (m == 0) return {1'b1, 48'd0};
    qx = (mx * 16384) / m;
    qy = (my * 16384) / m;
    qz = (mz * 16384) / m;
    nx = 16'((x < 0) ? -qx : qx);
    ny = 16'((y < 0) ? -qy : qy);
    nz = 16'((z < 0) ? -qz : qz);
    return {1'b0, nx, ny, nz};
  endfunction

  function automatic int rand_comp();
    int mode;
    logic signed [W-1:0] r;
    mode = int'($urandom_range(0, 5));
    case (mode)
      0: return 0;
      1: return -32768;
      2: return int'($urandom_range(0, 8)) - 4;
      default: begin
        r = W'($urandom);
        return int'(r);
      end
    endcase
  endfunction

  // Driver: wait for in_ready, present one vector for one accepting edge.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input int x, input int y, input int z);
    int n;
    n = 0;
    while (!in_ready && n <= 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      in_valid = 1'b1;
      dir_x = W'(x);
      dir_y = W'(y);
      dir_z = W'(z);
      exp_q.push_back(model(x, y, z));
      @(posedge clk); #1;
      in_valid = 1'b0;
      dir_x = W'($urandom);
      dir_y = W'($urandom);
      dir_z = W'($urandom);
    end
  endtask

  // Cycles from the accept edge until out_valid is seen high.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat <= 200) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  // Let the monitor consume all pending results.
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
  endtask

  // Monitor: compare every completed output transfer with the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got output 0x%0h, expected none",
                 {zero_vec, norm_x, norm_y, norm_z});
      end else begin
        check("result", 64'({zero_vec, norm_x, norm_y, norm_z}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Main sequence
  initial begin
    int lat;
    logic [EW-1:0] e;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dir_x = '0;
    dir_y = '0;
    dir_z = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_zero_vec", 64'(zero_vec), 64'd0);
    check("reset_norm", 64'({norm_x, norm_y, norm_z}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: basic vector and latency
    send(32'h0100, 32'h0080, 0);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_in_ready_low", 64'(in_ready), 64'd0);
    wait_out(lat);
    check("t1_latency", 64'(lat), 64'd47);
    drain(1'b0);

    // T2: sign applied after the divide
    send(-512, 256, 128);
    drain(1'b0);

    // T3: truncation and saturation
    send(3, 0, 1);
    drain(1'b0);
    send(-32768, 0, 16384);
    drain(1'b0);

    // T4: zero vector, then a non-zero vector clears zero_vec
    send(0, 0, 0);
    wait_out(lat);
    check("t4_zero_latency", 64'(lat), 64'd2);
    check("t4_zero_flag", 64'(zero_vec), 64'd1);
    drain(1'b0);
    send(32'h0100, 0, 0);
    check("t4_zero_vec_cleared", 64'(zero_vec), 64'd0);
    drain(1'b0);

    // T5: consumer back-pressure holds the result
    out_ready = 1'b0;
    e = model(-64, 256, 192);
    send(-64, 256, 192);
    wait_out(lat);
    check("t5_latency", 64'(lat), 64'd47);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("t5_hold", 64'({out_valid, in_ready, norm_x, norm_y, norm_z}),
            64'({1'b1, 1'b0, e[47:0]}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_released_in_ready", 64'(in_ready), 64'd1);
    check("t5_released_out_valid", 64'(out_valid), 64'd0);
    check("t5_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // T6: reset during the Y divide abandons the vector
    send(32'h0300, -512, 64);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    dir_x = 16'h7fff;
    dir_y = 16'h1234;
    dir_z = 16'h8001;
    exp_q.delete();
    @(posedge clk); #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_norm", 64'({norm_x, norm_y, norm_z}), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(32'h0100, 0, 0);
    wait_out(lat);
    check("t6_latency", 64'(lat), 64'd47);
    drain(1'b0);

    // Random vectors with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      send(rand_comp(), rand_comp(), rand_comp());
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
